sequence_display: RTL
=====================

SEQUENCE_DISPLAY -- requirements
Module: sequence_display

Interface
REQ-001 Parameter T_ON, default 1000, number of clock cycles each sequence item is lit.
REQ-002 Parameter T_OFF, default 500, number of blank clock cycles after each item.
REQ-003 Parameter N, default 10, timer width; SHALL satisfy 2^N > max(T_ON, T_OFF).
REQ-004 clock  in  1  single system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin playback; sampled only in OCIOSO.
REQ-007 para  in  1  synchronous abort of playback.
REQ-008 limite  in  4  index of last item to show (inclusive); registered at start.
REQ-009 dado  in  4  sequence memory data; synchronous ROM with 1-cycle read latency.
REQ-010 endereco  out  4  sequence memory address.
REQ-011 leds  out  4  one-hot item code shown to the player.
REQ-012 busy  out  1  high in every state except OCIOSO.
REQ-013 pronto  out  1  one-cycle pulse at playback completion.
REQ-014 db_estado  out  3  current FSM state encoding.

Function
REQ-015 States SHALL be OCIOSO, BUSCA, MOSTRA, APAGA and FIM.
REQ-016 OCIOSO: start=1 and para=0 -> BUSCA; endereco<=0; limite registered.
REQ-017 BUSCA SHALL last exactly 1 cycle (ROM latency), then MOSTRA.
REQ-018 MOSTRA: leds=dado; timer counts T_ON cycles, then APAGA.
REQ-019 APAGA: leds=0; timer counts T_OFF cycles; then FIM if endereco==registered limite, else endereco+1 and BUSCA.
REQ-020 FIM: pronto=1 for exactly one cycle, then OCIOSO; endereco holds last value.
REQ-021 leds SHALL be 4'b0000 in every state except MOSTRA.
REQ-022 Per-item time SHALL be 1+T_ON+T_OFF cycles; FIM reached 1+... total (limite+1)*(1+T_ON+T_OFF) cycles after start sampled.
REQ-023 limite=0 SHALL show one item; limite=15 SHALL show 16 items; endereco SHALL never wrap.
REQ-024 start while busy SHALL be ignored; limite input changes while busy SHALL be ignored.
REQ-025 para=1 in any busy state -> OCIOSO next cycle, leds=0, no pronto pulse.
REQ-026 start and para both high in OCIOSO: para wins, stay OCIOSO.
REQ-027 Timer SHALL clear on every state entry; no off-by-one: exactly T_ON / T_OFF cycles.

Reset
REQ-028 reset=0 SHALL immediately force OCIOSO, endereco=0, leds=0, busy=0, pronto=0, timer=0, registered limite=0, regardless of state.
REQ-029 Release of reset SHALL not start playback; a new start pulse is required.

Configuration
REQ-030 Macro SEQUENCE_DISPLAY_RGB_EN defined: extra output rgb (3 bits) SHALL show item colour during MOSTRA (0001->100, 0010->010, 0100->001, 1000->110, other->000) and 000 otherwise.
REQ-031 Macro undefined: rgb port and colour logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package SHALL hold the state encoding (OCIOSO=0, BUSCA=1, MOSTRA=2, APAGA=3, FIM=4) and default T_ON/T_OFF constants.
REQ-033 One sub-module, temporizador_exibicao (N-bit clear/enable counter with terminal-count compare), SHALL implement the timer.

Verification (T_ON=4, T_OFF=2, ROM = 0001,0010,0100,1000,...)
REQ-034 reset=0 in any state -> same cycle: leds=0000, endereco=0, busy=0, pronto=0, db_estado=0.
REQ-035 limite=2, start at edge 0 -> leds 0001 cycles 2-5, 0010 cycles 9-12, 0100 cycles 16-19, pronto=1 only cycle 22, busy=0 cycle 23.
REQ-036 limite=0, start -> leds 0001 cycles 2-5 only, pronto=1 cycle 8.
REQ-037 limite=3, para=1 in cycle 10 (second MOSTRA) -> OCIOSO cycle 11, leds=0000, no pronto; new start replays from endereco 0.
REQ-038 limite=1, start re-pulsed cycle 5 and limite changed to 15 cycle 6 -> exactly two items shown, pronto cycle 15.
REQ-039 reset=0 during APAGA of item 1 then released -> OCIOSO, no pronto; with RGB_EN, rgb=100 during item-0 MOSTRA and 000 in APAGA.

Source files
------------

// File: rtl/sequence_display_pkg.sv
// Shared definitions for the sequence display block.
//   - estado_t     : FSM state encoding, also exported on db_estado
//   - T_ON_DEFAULT : default lit time per item, in clock cycles
//   - T_OFF_DEFAULT: default blank time after each item, in clock cycles
//   - cor_item     : maps a one-hot item code to its RGB colour
//                    (only used when SEQUENCE_DISPLAY_RGB_EN is defined)
package sequence_display_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    BUSCA  = 3'd1,
    MOSTRA = 3'd2,
    APAGA  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam int T_ON_DEFAULT  = 1000;
  localparam int T_OFF_DEFAULT = 500;

  function automatic logic [2:0] cor_item(input logic [3:0] code);
    logic [2:0] cor;
    case (code)
      4'b0001: cor = 3'b100;
      4'b0010: cor = 3'b010;
      4'b0100: cor = 3'b001;
      4'b1000: cor = 3'b110;
      default: cor = 3'b000;
    endcase
    return cor;
  endfunction

endpackage

// File: rtl/sequence_display_if.sv
// Signal bundle between the sequence display and its environment.
//   start, para   : playback start / synchronous abort
//   limite        : index of the last item to show (inclusive)
//   dado          : data from the sequence ROM (1-cycle read latency)
//   endereco      : sequence ROM address
//   leds          : one-hot item code shown to the player
//   busy, pronto  : playback active / one-cycle completion pulse
//   db_estado     : current FSM state, for debug
//   rgb           : item colour, present only with SEQUENCE_DISPLAY_RGB_EN
// Modports: master = environment (drives inputs, ROM data), slave = display.
interface sequence_display_if;
  logic       start;
  logic       para;
  logic [3:0] limite;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       busy;
  logic       pronto;
  logic [2:0] db_estado;
`ifdef SEQUENCE_DISPLAY_RGB_EN
  logic [2:0] rgb;

  modport master (output start, para, limite, dado,
                  input  endereco, leds, busy, pronto, db_estado, rgb);
  modport slave  (input  start, para, limite, dado,
                  output endereco, leds, busy, pronto, db_estado, rgb);
`else
  modport master (output start, para, limite, dado,
                  input  endereco, leds, busy, pronto, db_estado);
  modport slave  (input  start, para, limite, dado,
                  output endereco, leds, busy, pronto, db_estado);
`endif
endinterface

// File: rtl/sequence_display_temporizador_exibicao.sv
// temporizador_exibicao: N-bit up counter with synchronous clear, count
// enable and terminal-count compare.
//   clock, reset     : system clock, asynchronous active-low reset
//   clear            : zero the count on the next edge (priority over enable)
//   enable           : advance the count by one
//   limite_contagem  : terminal value
//   fim_contagem     : high while the count equals limite_contagem
module temporizador_exibicao #(
  parameter int N = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [N-1:0] limite_contagem,
  output logic         fim_contagem
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign fim_contagem = (count_q == limite_contagem);

endmodule

// File: rtl/sequence_display.sv
// sequence_display: plays items 0..limite from a sequence ROM, each lit for
// T_ON cycles followed by T_OFF blank cycles, then pulses pronto.
//   clock  : system clock (rising edge)
//   reset  : asynchronous active-low reset
//   bus    : sequence_display_if.slave (start/para/limite/dado in;
//            endereco/leds/busy/pronto/db_estado out)
// Optional feature: define SEQUENCE_DISPLAY_RGB_EN to add the rgb colour
// output on the interface.
module sequence_display
  import sequence_display_pkg::*;
#(
  parameter int T_ON  = T_ON_DEFAULT,
  parameter int T_OFF = T_OFF_DEFAULT,
  parameter int N     = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  sequence_display_if.slave    bus
);

  // The timer runs from 0, so the terminal value is one less than the
  // number of cycles the state must last.
  localparam logic [N-1:0] ON_LAST  = N'(T_ON - 1);
  localparam logic [N-1:0] OFF_LAST = N'(T_OFF - 1);

  estado_t    state_q,    state_d;
  logic [3:0] endereco_q, endereco_d;
  logic [3:0] limite_q,   limite_d;

  logic         timer_clear;
  logic         timer_enable;
  logic [N-1:0] timer_limite;
  logic         timer_fim;

  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    case (state_q)
      OCIOSO: begin
        if (bus.start && !bus.para) begin
          state_d    = BUSCA;
          endereco_d = 4'd0;
          limite_d   = bus.limite;
        end
      end
      // One cycle for the ROM to return the item at endereco.
      BUSCA:  state_d = MOSTRA;
      MOSTRA: if (timer_fim) state_d = APAGA;
      APAGA: begin
        if (timer_fim) begin
          if (endereco_q == limite_q) begin
            state_d = FIM;
          end else begin
            state_d    = BUSCA;
            endereco_d = endereco_q + 4'd1;
          end
        end
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
    // Abort overrides every busy-state transition; address stays put.
    if (state_q != OCIOSO && bus.para) begin
      state_d    = OCIOSO;
      endereco_d = endereco_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= OCIOSO;
      endereco_q <= 4'd0;
      limite_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
    end
  end

  // Clearing on every transition gives each timed state a fresh count.
  assign timer_clear  = (state_d != state_q);
  assign timer_enable = (state_q == MOSTRA) || (state_q == APAGA);
  assign timer_limite = (state_q == MOSTRA) ? ON_LAST : OFF_LAST;

  temporizador_exibicao #(
    .N (N)
  ) u_temporizador (
    .clock           (clock),
    .reset           (reset),
    .clear           (timer_clear),
    .enable          (timer_enable),
    .limite_contagem (timer_limite),
    .fim_contagem    (timer_fim)
  );

  // Outputs decode straight from state so reset blanks them immediately.
  assign bus.endereco  = endereco_q;
  assign bus.leds      = (state_q == MOSTRA) ? bus.dado : 4'b0000;
  assign bus.busy      = (state_q != OCIOSO);
  assign bus.pronto    = (state_q == FIM);
  assign bus.db_estado = state_q;
`ifdef SEQUENCE_DISPLAY_RGB_EN
  assign bus.rgb       = (state_q == MOSTRA) ? cor_item(bus.dado) : 3'b000;
`endif

endmodule
